// File: rtl/dm_ctrl.sv
// Byte/half/word data memory with misalignment detection, configurable read latency
// and a valid/ready request, valid response handshake for the multi-cycle MIPS MEM stage.
module dm_ctrl #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam int unsigned CNT_W = 2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("dm_ctrl: RD_LAT must be in 1..4");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         lane_q, lane_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic [31:0]        rdata_d;
  logic               err_d;

  logic [31:0]        mem [DEPTH];

  logic               accept;
  logic               bad_req;
  logic               mem_we;
  logic [3:0]         be;
  logic [31:0]        wd;
  logic [IDX_W-1:0]   req_idx;

  // Lane extraction with sign/zero extension for sub-word loads
  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] lane,
                                           input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*lane +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: load_ext = uns ? {24'd0, b} : {{24{b[7]}}, b};
      SZ_HALF: load_ext = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: load_ext = word;
    endcase
  endfunction

  assign req_idx = req_addr[ADDR_W-1:2];
  assign accept  = req_valid & req_ready & ~rst;

  always_comb begin
    bad_req = 1'b0;
    case (req_size)
      SZ_BYTE: bad_req = 1'b0;
      SZ_HALF: bad_req = req_addr[0];
      SZ_WORD: bad_req = |req_addr[1:0];
      default: bad_req = 1'b1;
    endcase
  end

  // Store lane enables with the data replicated across every lane it may land in
  always_comb begin
    be = 4'b0000;
    wd = req_wdata;
    case (req_size)
      SZ_BYTE: begin
        be = 4'(4'b0001 << req_addr[1:0]);
        wd = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        be = req_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{req_wdata[15:0]}};
      end
      SZ_WORD: begin
        be = 4'b1111;
        wd = req_wdata;
      end
      default: begin
        be = 4'b0000;
        wd = req_wdata;
      end
    endcase
  end

  assign mem_we = accept & req_we & ~bad_req;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we && be[i]) mem[req_idx][8*i +: 8] <= wd[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rdata_d = resp_rdata;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          idx_d  = req_idx;
          lane_d = req_addr[1:0];
          size_d = req_size;
          uns_d  = req_unsigned;
          if (bad_req) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else if (req_we) begin
            state_d = RESP;
          end else begin
            state_d = RD_WAIT;
            cnt_d   = CNT_W'(RD_LAT - 1);
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          rdata_d = load_ext(mem[idx_q], lane_q, size_q, uns_q);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      lane_q     <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      lane_q     <= lane_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      req_ready  <= (state_d == IDLE);
      resp_valid <= (state_d == RESP);
      resp_err   <= err_d;
      resp_rdata <= rdata_d;
    end
  end

endmodule
